// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler: NS/EW green-yellow-clear cycle with demand-driven gapping.
// Optional pedestrian walk phase is built only when TRAFFIC_PED_PHASE_EN is defined.
module traffic_phase_scheduler #(
    parameter logic [7:0] MIN_GREEN   = 8'd4,
    parameter logic [7:0] MAX_GREEN   = 8'd8,
    parameter logic [7:0] YELLOW_TIME = 8'd3,
    parameter logic [7:0] CLEAR_TIME  = 8'd1,
    parameter logic [7:0] PED_TIME    = 8'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic [2:0] n_light,
    output logic [2:0] s_light,
    output logic [2:0] e_light,
    output logic [2:0] w_light,
    output logic       ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        NS_CLEAR  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        EW_CLEAR  = 3'd5,
        PED_WALK  = 3'd6,
        ILLEGAL   = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [7:0] TIMER_MAX   = 8'hFF;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic [8:0] elapsed;
    logic       legal;
    logic       ns_opp;
    logic       ew_opp;
    logic       ped_pend_w;

`ifdef TRAFFIC_PED_PHASE_EN
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;
    logic ped_pending;
    logic next_dir;
    assign ped_pend_w = ped_pending;
`else
    logic ped_unused;
    assign ped_unused = ped_req;
    assign ped_pend_w = 1'b0;
`endif

    // elapsed is one wider than the timer so a saturated timer still compares correctly
    assign elapsed = {1'b0, timer} + 9'd1;
    assign ns_opp  = ew_req | ped_pend_w;
    assign ew_opp  = ns_req | ped_pend_w;

    function automatic logic green_done(input logic [8:0] el, input logic opp, input logic own);
        return (el >= {1'b0, MIN_GREEN}) && opp && (!own || (el >= {1'b0, MAX_GREEN}));
    endfunction

    always_comb begin
        state_nxt = state;
        legal     = 1'b1;
        case (state)
            NS_GREEN:  if (green_done(elapsed, ns_opp, ns_req)) state_nxt = NS_YELLOW;
            NS_YELLOW: if (timer == YELLOW_TIME - 8'd1) state_nxt = NS_CLEAR;
            NS_CLEAR:  if (timer == CLEAR_TIME - 8'd1) state_nxt = ped_pend_w ? PED_WALK : EW_GREEN;
            EW_GREEN:  if (green_done(elapsed, ew_opp, ew_req)) state_nxt = EW_YELLOW;
            EW_YELLOW: if (timer == YELLOW_TIME - 8'd1) state_nxt = EW_CLEAR;
            EW_CLEAR:  if (timer == CLEAR_TIME - 8'd1) state_nxt = ped_pend_w ? PED_WALK : NS_GREEN;
`ifdef TRAFFIC_PED_PHASE_EN
            PED_WALK:  if (timer == PED_TIME - 8'd1) state_nxt = (next_dir == DIR_EW) ? EW_GREEN : NS_GREEN;
`endif
            default: begin
                state_nxt = NS_GREEN;
                legal     = 1'b0;
            end
        endcase
    end

    // Illegal codes recover on the next clock whether or not tick is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NS_GREEN;
            timer <= '0;
        end else if (!legal) begin
            state <= NS_GREEN;
            timer <= '0;
        end else if (tick) begin
            state <= state_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer != TIMER_MAX) begin
                timer <= timer + 8'd1;
            end
        end
    end

`ifdef TRAFFIC_PED_PHASE_EN
    // A press on the walk-entry clock or during the walk is absorbed by the walk being served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
            next_dir    <= DIR_EW;
        end else begin
            if (legal && tick && (state_nxt == PED_WALK) && (state != PED_WALK)) begin
                ped_pending <= 1'b0;
            end else if (ped_req && (state != PED_WALK)) begin
                ped_pending <= 1'b1;
            end
            if (legal && tick && (state == NS_CLEAR) && (state_nxt != NS_CLEAR)) begin
                next_dir <= DIR_EW;
            end else if (legal && tick && (state == EW_CLEAR) && (state_nxt != EW_CLEAR)) begin
                next_dir <= DIR_NS;
            end
        end
    end
`endif

    always_comb begin
        n_light  = LAMP_RED;
        s_light  = LAMP_RED;
        e_light  = LAMP_RED;
        w_light  = LAMP_RED;
        ped_walk = 1'b0;
        case (state)
            NS_GREEN: begin
                n_light = LAMP_GREEN;
                s_light = LAMP_GREEN;
            end
            NS_YELLOW: begin
                n_light = LAMP_YELLOW;
                s_light = LAMP_YELLOW;
            end
            EW_GREEN: begin
                e_light = LAMP_GREEN;
                w_light = LAMP_GREEN;
            end
            EW_YELLOW: begin
                e_light = LAMP_YELLOW;
                w_light = LAMP_YELLOW;
            end
`ifdef TRAFFIC_PED_PHASE_EN
            PED_WALK: ped_walk = 1'b1;
`endif
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: a phase-level reference model predicts
// the visible outputs after every clock and a monitor compares them on the falling edge.
module tb_traffic_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 8;
  localparam int YEL   = 3;
  localparam int CLR   = 1;
  localparam int PED   = 5;
`ifdef TRAFFIC_PED_PHASE_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic ns_req = 1'b0;
  logic ew_req = 1'b0;
  logic ped_req = 1'b0;
  logic [2:0] n_light, s_light, e_light, w_light, phase;
  logic ped_walk;

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
    .n_light(n_light), .s_light(s_light), .e_light(e_light), .w_light(w_light),
    .ped_walk(ped_walk), .phase(phase)
  );

  // reference model: phase name as spec code, ticks spent in phase, pending walk, direction after walk
  int m_phase;
  int m_ticks;
  bit m_pend;
  bit m_next_ew;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] expect_word(input int ph);
    logic [2:0] ns_l, ew_l;
    logic walk;
    ns_l = 3'b100;
    ew_l = 3'b100;
    walk = 1'b0;
    if (ph == 0) ns_l = 3'b001;
    if (ph == 1) ns_l = 3'b010;
    if (ph == 3) ew_l = 3'b001;
    if (ph == 4) ew_l = 3'b010;
    if (ph == 6) walk = 1'b1;
    return {ph[2:0], ns_l, ns_l, ew_l, ew_l, walk};
  endfunction

  function automatic int fixed_len(input int ph);
    case (ph)
      1, 4: return YEL;
      2, 5: return CLR;
      default: return PED;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_ticks = 0;
    m_pend = 0;
    m_next_ew = 1;
  endtask

  task automatic model_step(input bit t, input bit ns, input bit ew, input bit ped);
    int nxt;
    int spent;
    nxt = m_phase;
    if (t) begin
      spent = m_ticks + 1;
      if (m_phase == 0 || m_phase == 3) begin
        bit own, opp;
        own = (m_phase == 0) ? ns : ew;
        opp = ((m_phase == 0) ? ew : ns) || m_pend;
        if (spent >= MIN_G && opp && (!own || spent >= MAX_G)) nxt = m_phase + 1;
      end else if (spent == fixed_len(m_phase)) begin
        case (m_phase)
          1: nxt = 2;
          4: nxt = 5;
          2: begin nxt = m_pend ? 6 : 3; m_next_ew = 1; end
          5: begin nxt = m_pend ? 6 : 0; m_next_ew = 0; end
          default: nxt = m_next_ew ? 3 : 0;
        endcase
      end
      if (nxt != m_phase) m_ticks = 0;
      else if (m_ticks < 255) m_ticks = spent;
    end
    if (nxt == 6 && m_phase != 6) m_pend = 0;
    else if (PED_EN && ped && m_phase != 6) m_pend = 1;
    m_phase = nxt;
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got phase=%0d lamps n/s/e/w=%b/%b/%b/%b walk=%b, expected phase=%0d lamps=%b/%b/%b/%b walk=%b",
               name, act[15:13], act[12:10], act[9:7], act[6:4], act[3:1], act[0],
               exp[15:13], exp[12:10], exp[9:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  function automatic logic [15:0] dut_word();
    return {phase, n_light, s_light, e_light, w_light, ped_walk};
  endfunction

  // monitor: one prediction per clock, compared away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check_word("out_word", dut_word(), exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step(input bit t, input bit ns, input bit ew, input bit ped);
    tick = t;
    ns_req = ns;
    ew_req = ew;
    ped_req = ped;
    @(posedge clk);
    #1;
    model_step(t, ns, ew, ped);
    exp_q.push_back(expect_word(m_phase));
  endtask

  // reset asserted between edges; outputs must already show the reset decode
  task automatic apply_reset(input string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    tick = 1'b0;
    ns_req = 1'b0;
    ew_req = 1'b0;
    ped_req = 1'b0;
    #1;
    check_word(name, dut_word(), expect_word(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until(input string name, input int target, input bit ns, input bit ew);
    for (int i = 0; i < 60 && m_phase != target; i++) step(1, ns, ew, 0);
    checks++;
    if (m_phase != target) begin
      errors++;
      $display("FAIL %s: phase %0d not reached within budget, model phase=%0d", name, target, m_phase);
    end
  endtask

  initial begin
    bit r_ns, r_ew;
    model_reset();
    #3;
    check_word("reset_hold", dut_word(), expect_word(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // idle: green rests on NS
    for (int i = 0; i < 100; i++) step(1, 0, 0, 0);

    // EW demand only: one NS->EW transfer, then rest
    apply_reset("reset_before_ew");
    for (int i = 0; i < 30; i++) step(1, 0, 1, 0);

    // both demands: max-green alternation
    apply_reset("reset_before_both");
    for (int i = 0; i < 50; i++) step(1, 1, 1, 0);

    // pedestrian pulse at clock 2 of NS green
    apply_reset("reset_before_ped");
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0);

    // tick withheld during NS yellow
    apply_reset("reset_before_hold");
    run_until("reach_ns_yellow", 1, 0, 1);
    step(1, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0);

    // randomized traffic with sparse ticks
    apply_reset("reset_before_random");
    r_ns = 0;
    r_ew = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) r_ns = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) r_ew = $urandom_range(0, 1);
      step($urandom_range(0, 3) != 0, r_ns, r_ew, $urandom_range(0, 19) == 0);
    end

    // asynchronous reset from the middle of EW yellow
    apply_reset("reset_before_async");
    run_until("reach_ew_green", 3, 0, 1);
    run_until("reach_ew_yellow", 4, 1, 0);
    step(1, 1, 0, 1);
    apply_reset("async_reset_ew_yellow");
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);

    // final report
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
